// File: rtl/i2c_reg_init_seq.sv
// rtl/i2c_reg_init_seq.sv - table-driven I2C register init sequencer with per-entry NACK retry
// Optional feature macro: I2C_CFG_DELAY_EN (entries with upper byte 8'hFF become delay opcodes)
module i2c_reg_init_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         ENTRIES    = 12,
  parameter int         IDX_W      = 4,
  parameter int         DATA_W     = 16,
  parameter int         MAX_RETRY  = 3,
  parameter int         DELAY_UNIT = 1000
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                i_START,
  output logic [IDX_W-1:0]    o_TBL_ADDR,
  input  logic [DATA_W-1:0]   i_TBL_DATA,
  output logic [8+DATA_W-1:0] o_XFER_DATA,
  output logic                o_XFER_GO,
  input  logic                i_XFER_END,
  input  logic                i_XFER_ACK,
  output logic                o_BUSY,
  output logic                o_DONE,
  output logic                o_ERR,
  output logic [IDX_W-1:0]    o_ERR_INDEX
);

  localparam int               RTY_W    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RTY_W-1:0] LAST_TRY = RTY_W'(MAX_RETRY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  if (MAX_RETRY < 1 || DELAY_UNIT < 1 || ENTRIES < 1 || ENTRIES > (1 << IDX_W)) begin : gBadParam
    $error("i2c_reg_init_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    FETCH, LATCH, GO, WAIT, NEXT, DONE, FAIL
`ifdef I2C_CFG_DELAY_EN
    , DELAY
`endif
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [RTY_W-1:0] retry;

`ifdef I2C_CFG_DELAY_EN
  localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
  logic [DLY_W-1:0] delayCnt;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state       <= FETCH;
      idx         <= '0;
      retry       <= '0;
      o_XFER_GO   <= 1'b0;
      o_XFER_DATA <= '0;
      o_TBL_ADDR  <= '0;
      o_BUSY      <= 1'b1;
      o_DONE      <= 1'b0;
      o_ERR       <= 1'b0;
      o_ERR_INDEX <= '0;
`ifdef I2C_CFG_DELAY_EN
      delayCnt    <= '0;
`endif
    end else begin
      case (state)
        FETCH: begin
          o_TBL_ADDR <= idx;
          state      <= LATCH;
        end
        LATCH: begin
          o_XFER_DATA <= {DEV_ADDR, i_TBL_DATA};
          state       <= GO;
`ifdef I2C_CFG_DELAY_EN
          // Delay opcodes never reach the bus; the later assignment overrides GO.
          if (i_TBL_DATA[DATA_W-1 -: 8] == 8'hFF) begin
            delayCnt <= DLY_W'(i_TBL_DATA[7:0]) * DLY_W'(DELAY_UNIT);
            state    <= DELAY;
          end
`endif
        end
        GO: begin
          o_XFER_GO <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (i_XFER_END) begin
            o_XFER_GO <= 1'b0;
            if (!i_XFER_ACK) begin
              state <= NEXT;
            end else if (retry != LAST_TRY) begin
              retry <= retry + 1'b1;
              state <= GO;
            end else begin
              state       <= FAIL;
              o_BUSY      <= 1'b0;
              o_ERR       <= 1'b1;
              o_ERR_INDEX <= idx;
            end
          end
        end
        NEXT: begin
          retry <= '0;
          // Stop on the last index instead of incrementing, so a full-range table never wraps.
          if (idx == LAST_IDX) begin
            state  <= DONE;
            o_BUSY <= 1'b0;
            o_DONE <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
`ifdef I2C_CFG_DELAY_EN
        DELAY: begin
          if (delayCnt <= DLY_W'(1)) state <= NEXT;
          else delayCnt <= delayCnt - 1'b1;
        end
`endif
        DONE, FAIL: begin
          if (i_START) begin
            o_DONE      <= 1'b0;
            o_ERR       <= 1'b0;
            o_ERR_INDEX <= '0;
            o_BUSY      <= 1'b1;
            idx         <= '0;
            retry       <= '0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
